// File: rtl/llc_mem_responder.sv
// Memory-side responder for the LLC fill/write-back channel: serializes one cache line
// into word beats on a command/data memory port and gathers fill beats back into a line.
module llc_mem_responder #(
    parameter int ADDR_BITS      = 32,
    parameter int WORD_BITS      = 64,
    parameter int WORDS_PER_LINE = 2,
    parameter int LINE_ADDR_BITS = 28
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                llc_mem_req_valid,
    output logic                                llc_mem_req_ready,
    input  logic                                llc_mem_req_hwrite,
    input  logic [1:0]                          llc_mem_req_hprot,
    input  logic [LINE_ADDR_BITS-1:0]           llc_mem_req_addr,
    input  logic [WORDS_PER_LINE*WORD_BITS-1:0] llc_mem_req_line,
    output logic                                llc_mem_rsp_valid,
    input  logic                                llc_mem_rsp_ready,
    output logic [WORDS_PER_LINE*WORD_BITS-1:0] llc_mem_rsp_line,
    output logic                                mem_cmd_valid,
    input  logic                                mem_cmd_ready,
    output logic                                mem_cmd_write,
    output logic [1:0]                          mem_cmd_hprot,
    output logic [ADDR_BITS-1:0]                mem_cmd_addr,
    output logic [WORD_BITS-1:0]                mem_cmd_wdata,
    input  logic                                mem_rdata_valid,
    input  logic [WORD_BITS-1:0]                mem_rdata,
    output logic [2:0]                          dbg_state_o
);

    localparam int LINE_BITS = WORDS_PER_LINE * WORD_BITS;
    localparam int BEAT_BITS = $clog2(WORDS_PER_LINE);
    localparam int OFF_BITS  = $clog2(WORD_BITS / 8);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(WORDS_PER_LINE - 1);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
    // valid never depends combinationally on ready, and payload holds while valid waits.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_BEAT = 3'd1,
        RD_CMD  = 3'd2,
        RD_DATA = 3'd3,
        RSP     = 3'd4
    } state_e;

    state_e                      state_q, state_d;
    logic [BEAT_BITS-1:0]        beat_q, beat_d;
    logic [LINE_ADDR_BITS-1:0]   addr_q, addr_d;
    logic [1:0]                  hprot_q, hprot_d;
    logic [LINE_BITS-1:0]        wline_q, wline_d;
    logic [LINE_BITS-1:0]        fill_q, fill_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            hprot_q <= '0;
            wline_q <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            hprot_q <= hprot_d;
            wline_q <= wline_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        hprot_d = hprot_q;
        wline_d = wline_q;
        fill_d  = fill_q;
        case (state_q)
            IDLE: begin
                if (llc_mem_req_valid) begin
                    addr_d  = llc_mem_req_addr;
                    hprot_d = llc_mem_req_hprot;
                    wline_d = llc_mem_req_line;
                    beat_d  = '0;
                    state_d = llc_mem_req_hwrite ? WR_BEAT : RD_CMD;
                end
            end
            WR_BEAT: begin
                if (mem_cmd_ready) begin
                    beat_d = beat_q + BEAT_BITS'(1);
                    if (beat_q == LAST_BEAT) state_d = IDLE;
                end
            end
            RD_CMD: begin
                if (mem_cmd_ready) state_d = RD_DATA;
            end
            RD_DATA: begin
                // Read data is accepted only here; beats arriving in any other state are dropped.
                if (mem_rdata_valid) begin
                    fill_d[int'(beat_q)*WORD_BITS +: WORD_BITS] = mem_rdata;
                    beat_d  = beat_q + BEAT_BITS'(1);
                    state_d = (beat_q == LAST_BEAT) ? RSP : RD_CMD;
                end
            end
            RSP: begin
                if (llc_mem_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is a decode of registered state, so nothing flows straight from an input.
    assign llc_mem_req_ready = (state_q == IDLE);
    assign llc_mem_rsp_valid = (state_q == RSP);
    assign llc_mem_rsp_line  = fill_q;
    assign mem_cmd_valid     = (state_q == WR_BEAT) || (state_q == RD_CMD);
    assign mem_cmd_write     = (state_q == WR_BEAT);
    assign mem_cmd_hprot     = hprot_q;
    assign mem_cmd_addr      = ADDR_BITS'({addr_q, beat_q, {OFF_BITS{1'b0}}});
    assign mem_cmd_wdata     = wline_q[int'(beat_q)*WORD_BITS +: WORD_BITS];
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_llc_mem_responder.sv
// Bench for llc_mem_responder: directed timing cases plus randomized transactions checked
// against a line-level memory model and an expected-command queue.
module tb_llc_mem_responder;

  localparam int AB    = 32;
  localparam int WB    = 64;
  localparam int WPL   = 2;
  localparam int LAB   = 28;
  localparam int LB    = WPL * WB;
  localparam int CMD_W = 1 + 2 + AB + WB;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid, req_ready, req_hwrite;
  logic [1:0]     req_hprot;
  logic [LAB-1:0] req_addr;
  logic [LB-1:0]  req_line;
  logic           rsp_valid, rsp_ready;
  logic [LB-1:0]  rsp_line;
  logic           cmd_valid, cmd_ready, cmd_write;
  logic [1:0]     cmd_hprot;
  logic [AB-1:0]  cmd_addr;
  logic [WB-1:0]  cmd_wdata;
  logic           rdata_valid;
  logic [WB-1:0]  rdata;
  logic [2:0]     dbg_state;

  llc_mem_responder dut (
    .clk(clk), .rst(rst),
    .llc_mem_req_valid(req_valid), .llc_mem_req_ready(req_ready),
    .llc_mem_req_hwrite(req_hwrite), .llc_mem_req_hprot(req_hprot),
    .llc_mem_req_addr(req_addr), .llc_mem_req_line(req_line),
    .llc_mem_rsp_valid(rsp_valid), .llc_mem_rsp_ready(rsp_ready),
    .llc_mem_rsp_line(rsp_line),
    .mem_cmd_valid(cmd_valid), .mem_cmd_ready(cmd_ready), .mem_cmd_write(cmd_write),
    .mem_cmd_hprot(cmd_hprot), .mem_cmd_addr(cmd_addr), .mem_cmd_wdata(cmd_wdata),
    .mem_rdata_valid(rdata_valid), .mem_rdata(rdata),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  logic [CMD_W-1:0] exp_q[$];
  logic [WB-1:0]    dir_q[$];
  logic [31:0]      salt;
  logic [LB-1:0]    last_fill;

  function automatic logic [WB-1:0] mem_word(input logic [AB-1:0] a);
    return {salt, a};
  endfunction

  function automatic logic [CMD_W-1:0] cmd_pack(input logic wr, input logic [1:0] hp,
                                                input logic [AB-1:0] a, input logic [WB-1:0] wd);
    return {wr, hp, a, (wr ? wd : {WB{1'b0}})};
  endfunction

  function automatic logic [AB-1:0] beat_addr(input logic [LAB-1:0] a, input int i);
    return AB'(a) * AB'(WPL * WB / 8) + AB'(i * (WB / 8));
  endfunction

  function automatic logic [LB-1:0] model_fill(input logic [LAB-1:0] a);
    logic [LB-1:0] l;
    l = '0;
    for (int i = 0; i < WPL; i++) l[i*WB +: WB] = mem_word(beat_addr(a, i));
    return l;
  endfunction

  // ---------------- memory side ----------------
  bit            mem_rand_rdy = 0;
  bit            spur_en = 0;
  bit            stall_arm = 0;
  int            stall_hits = 0;
  int            lat_min = 1, lat_max = 1;
  int            cmd_cnt = 0;
  int            rd_cnt = 0;
  int            stall_left = 0;
  logic [AB-1:0] rd_addr;
  logic [AB+WB-1:0] stall_ref;

  initial begin
    cmd_ready = 1'b0;
    rdata_valid = 1'b0;
    rdata = '0;
    forever begin
      @(negedge clk);
      rdata_valid = 1'b0;
      if (!rst) begin
        rd_cnt = 0;
        stall_left = 0;
        cmd_ready = 1'b0;
      end else begin
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            rdata_valid = 1'b1;
            rdata = (dir_q.size() > 0) ? dir_q.pop_front() : mem_word(rd_addr);
          end
        end else if (spur_en && $urandom_range(0, 2) == 0) begin
          rdata_valid = 1'b1;
          rdata = {$urandom, $urandom};
        end
        if (stall_left > 0) begin
          check("stall_stable", {cmd_valid, cmd_addr, cmd_wdata}, {1'b1, stall_ref});
          stall_left--;
          cmd_ready = 1'b0;
        end else if (stall_arm && cmd_valid && cmd_write && cmd_addr[3]) begin
          stall_arm = 0;
          stall_hits++;
          stall_ref = {cmd_addr, cmd_wdata};
          stall_left = 3;
          cmd_ready = 1'b0;
        end else begin
          cmd_ready = mem_rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (cmd_valid && cmd_ready) begin
          cmd_cnt++;
          check("one_outstanding", rd_cnt, 0);
          if (exp_q.size() == 0) check("cmd_unexpected", 1, 0);
          else check("cmd", cmd_pack(cmd_write, cmd_hprot, cmd_addr, cmd_wdata), exp_q.pop_front());
          if (!cmd_write) begin
            rd_cnt = $urandom_range(lat_min, lat_max);
            rd_addr = cmd_addr;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int accept_cyc = 0;

  task automatic do_req(input logic wr, input logic [1:0] hp, input logic [LAB-1:0] a,
                        input logic [LB-1:0] line, output int waits);
    for (int i = 0; i < WPL; i++)
      exp_q.push_back(cmd_pack(wr, hp, beat_addr(a, i), line[i*WB +: WB]));
    req_valid = 1'b1; req_hwrite = wr; req_hprot = hp; req_addr = a; req_line = line;
    waits = 0;
    while (!req_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) check("req_accept_timeout", 1, 0);
    @(negedge clk);
    accept_cyc = cyc;
    req_valid = 1'b0;
    check("req_ready_low_after_accept", req_ready, 0);
  endtask

  task automatic wait_write(output int done_rel);
    int  n;
    bit  saw_rsp;
    n = 0;
    saw_rsp = 0;
    while (!req_ready && n < 300) begin
      if (rsp_valid) saw_rsp = 1;
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("wr_timeout", 1, 0);
    done_rel = cyc - accept_cyc + 1;
    check("wr_no_rsp", saw_rsp, 0);
    check("wr_all_beats", exp_q.size(), 0);
    check("wr_fill_kept", rsp_line, last_fill);
  endtask

  task automatic wait_read(input logic [LB-1:0] exp_line, input int hold, output int vrel);
    int n;
    n = 0;
    rsp_ready = 1'b0;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    vrel = cyc - accept_cyc + 1;
    if (!rsp_valid) begin
      check("rd_timeout", 1, 0);
    end else begin
      for (int k = 0; k < hold; k++) begin
        check("rsp_hold", {rsp_valid, rsp_line}, {1'b1, exp_line});
        @(negedge clk);
      end
      check("rsp_line", rsp_line, exp_line);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rd_idle_after_rsp", {req_ready, rsp_valid}, 2'b10);
      check("rd_all_cmds", exp_q.size(), 0);
      last_fill = exp_line;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waits, rel, base;
    logic [LAB-1:0] a;
    logic [LB-1:0]  l;
    logic [LB-1:0]  e;
    logic           wr;

    rst = 1'b0;
    req_valid = 1'b0; req_hwrite = 1'b0; req_hprot = '0; req_addr = '0; req_line = '0;
    rsp_ready = 1'b0;
    salt = 32'h5a5a0001;
    last_fill = '0;
    repeat (3) @(negedge clk);
    check("reset_ready_valids", {req_ready, rsp_valid, cmd_valid}, 3'b100);
    check("reset_cmd_outputs", {cmd_write, cmd_hprot, cmd_addr, cmd_wdata}, '0);
    check("reset_fill", rsp_line, '0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_release", {req_ready, rsp_valid, cmd_valid, cmd_addr}, {3'b100, 32'h0});

    // Directed write-back, memory always ready.
    l = {{16{4'hB}}, {16{4'hA}}};
    do_req(1'b1, 2'b01, 28'h0000123, l, waits);
    wait_write(rel);
    check("wr_ready_again_cycle", rel, WPL + 1);

    // Directed fill: memory returns 0x11 then 0x22, one-cycle latency, LLC stalls 3 cycles.
    dir_q.push_back(64'h11);
    dir_q.push_back(64'h22);
    do_req(1'b0, 2'b10, 28'h0000040, '0, waits);
    wait_read({64'h22, 64'h11}, 3, rel);
    check("rd_rsp_valid_cycle", rel, 5);

    // Write beat 1 held off for 4 cycles.
    stall_arm = 1;
    l = {$urandom, $urandom, $urandom, $urandom};
    do_req(1'b1, 2'b11, 28'h0abcdef, l, waits);
    wait_write(rel);
    check("stall_taken", stall_hits, 1);

    // Spurious read beats outside RD_DATA, then a back-to-back request on the release cycle.
    spur_en = 1;
    do_req(1'b1, 2'b00, 28'h0000777, {$urandom, $urandom, $urandom, $urandom}, waits);
    wait_write(rel);
    do_req(1'b1, 2'b01, 28'h0000778, {$urandom, $urandom, $urandom, $urandom}, waits);
    check("b2b_accept_waits", waits, 0);
    wait_write(rel);
    spur_en = 0;

    // Reset while waiting for the second read beat.
    lat_min = 3; lat_max = 3;
    salt = 32'hdead0002;
    base = cmd_cnt;
    do_req(1'b0, 2'b01, 28'h0000200, '0, waits);
    rel = 0;
    while (cmd_cnt < base + 2 && rel < 100) begin
      @(negedge clk);
      #1;
      rel++;
    end
    check("rst_test_reached_beat1", cmd_cnt, base + 2);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_outputs", {req_ready, rsp_valid, cmd_valid}, 3'b100);
    exp_q.delete();
    dir_q.delete();
    repeat (2) @(negedge clk);
    check("rst_fill_cleared", rsp_line, '0);
    last_fill = '0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_release_ready", req_ready, 1);
    lat_min = 1; lat_max = 3;
    salt = 32'hbeef0003;
    a = 28'h0000200;
    e = model_fill(a);
    do_req(1'b0, 2'b10, a, '0, waits);
    wait_read(e, 1, rel);

    // Randomized traffic.
    mem_rand_rdy = 1;
    spur_en = 1;
    for (int t = 0; t < 40; t++) begin
      salt = $urandom;
      wr = 1'($urandom_range(0, 1));
      a = LAB'({$urandom});
      l = {$urandom, $urandom, $urandom, $urandom};
      e = model_fill(a);
      do_req(wr, 2'($urandom_range(0, 3)), a, l, waits);
      if (wr) wait_write(rel);
      else wait_read(e, $urandom_range(0, 2), rel);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    spur_en = 0;
    mem_rand_rdy = 0;
    repeat (3) @(negedge clk);
    check("final_idle", {req_ready, rsp_valid, cmd_valid}, 3'b100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/llc_mem_responder.md
# llc_mem_responder

Memory-side responder for the LLC `llc_mem_req` / `llc_mem_rsp` channel pair. It accepts one cache-line request at a time from the LLC core and serializes it into word-wide beats on a simple command/data memory port. Write-backs complete silently. Fills gather beats into a full line and return it on `llc_mem_rsp`. It sits between the LLC core and the memory controller / DRAM model.

## Interface
Parameters:
- `ADDR_BITS`, 32, byte-address width.
- `WORD_BITS`, 64, memory data-bus width (one beat).
- `WORDS_PER_LINE`, 2, beats per cache line; power of two, ≥2.
- `LINE_ADDR_BITS`, 28, equals `ADDR_BITS − log2(WORDS_PER_LINE·WORD_BITS/8)`.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock.
  - `rst`  in  1  asynchronous active-low reset.
- LLC request channel:
  - `llc_mem_req_valid`  in  1  LLC request valid.
  - `llc_mem_req_ready`  out  1  responder can accept a request.
  - `llc_mem_req_hwrite`  in  1  1 = write-back, 0 = fill.
  - `llc_mem_req_hprot`  in  2  protection bits, forwarded on every beat.
  - `llc_mem_req_addr`  in  LINE_ADDR_BITS  line address.
  - `llc_mem_req_line`  in  WORDS_PER_LINE·WORD_BITS  write data.
- LLC response channel:
  - `llc_mem_rsp_valid`  out  1  fill line valid.
  - `llc_mem_rsp_ready`  in  1  LLC accepts the fill.
  - `llc_mem_rsp_line`  out  WORDS_PER_LINE·WORD_BITS  fill data.
- Memory command port:
  - `mem_cmd_valid`  out  1  memory command valid.
  - `mem_cmd_ready`  in  1  memory accepts the command.
  - `mem_cmd_write`  out  1  command is a write.
  - `mem_cmd_hprot`  out  2  registered hprot.
  - `mem_cmd_addr`  out  ADDR_BITS  byte address of the beat, `{line_addr, beat_idx, zeros}`.
  - `mem_cmd_wdata`  out  WORD_BITS  write beat.
- Memory read-data port:
  - `mem_rdata_valid`  in  1  read beat valid; no backpressure.
  - `mem_rdata`  in  WORD_BITS  read beat.

## Operation
- FSM states:
  - IDLE: `llc_mem_req_ready`=1. On `llc_mem_req_valid`, register addr, hprot, hwrite and line, clear beat counter, then go to WR_BEAT (hwrite=1) or RD_CMD (hwrite=0).
  - WR_BEAT:
    - Drive `mem_cmd_valid`=1, `write`=1, `wdata` = line word[beat].
    - On `mem_cmd_ready`: beat++. If beat was `WORDS_PER_LINE−1`, go to IDLE.
    - No LLC response is issued for writes.
  - RD_CMD: drive `mem_cmd_valid`=1, `write`=0. On `mem_cmd_ready`, go to RD_DATA.
  - RD_DATA:
    - Wait for `mem_rdata_valid` and store the beat in fill word[beat].
    - Last beat: go to RSP. Otherwise beat++ and go to RD_CMD.
  - RSP: `llc_mem_rsp_valid`=1 with the assembled line held stable. On `llc_mem_rsp_ready`, go to IDLE.
- Word order: word 0 occupies line bits [WORD_BITS−1:0] at the lowest address.
- Beat counter is `log2(WORDS_PER_LINE)` bits wide and wraps to 0 after the last beat.
- `mem_cmd_*` data/address outputs are driven from registers. They are stable while `mem_cmd_valid` is high and unacknowledged.
- `mem_rdata_valid` outside RD_DATA is ignored; fill data is unchanged.
- Only one outstanding command exists at a time. A read command must return its data before the next command is issued.

## Timing
- Reset values: state IDLE, beat 0, fill line 0.
  - `llc_mem_req_ready`=1.
  - `llc_mem_rsp_valid`=0, `mem_cmd_valid`=0.
  - All data/address outputs are 0.
- Reset mid-operation: immediate return to IDLE. The in-flight transaction is dropped and all valids deassert asynchronously.
- Request accepted at edge T (valid & ready): `llc_mem_req_ready`=0 from T+1 until the transaction finishes.
- Write, memory always ready:
  - Beats at cycles T+1 … T+WORDS_PER_LINE.
  - `llc_mem_req_ready`=1 again in cycle T+WORDS_PER_LINE+1.
- Read, memory ready and 1-cycle rdata latency (WORDS_PER_LINE=2):
  - cmd0 at T+1, rdata0 at T+2.
  - cmd1 at T+3, rdata1 at T+4.
  - `llc_mem_rsp_valid` at T+5.
  - Back to IDLE and ready=1 the cycle after the rsp handshake.
- No combinational path from any input to `mem_cmd_*` or `llc_mem_rsp_*`.
- `llc_mem_req_ready` is a decode of the state only.

## Test plan
- Reset, then idle: check `llc_mem_req_ready`=1, all valids 0, `mem_cmd_addr`=0.
- Write request, addr=0x0000123, line={64'hBBBB…, 64'hAAAA…}, mem always ready:
  - Beat 0 at byte address 0x00001230 with wdata AAAA….
  - Beat 1 at 0x00001238 with wdata BBBB….
  - `llc_mem_rsp_valid` never rises.
- Read request, addr=0x0000040, memory returns 0x11 then 0x22:
  - `llc_mem_rsp_line`={64'h22, 64'h11}, valid at T+5.
  - Line held while `llc_mem_rsp_ready`=0 for 3 cycles.
- `mem_cmd_ready` low for 4 cycles on write beat 1: addr and wdata stay stable; beat is not skipped or duplicated.
- Spurious `mem_rdata_valid` in IDLE and WR_BEAT: no state change and fill data unchanged. A back-to-back request on the release cycle is accepted.
- `rst` asserted during RD_DATA after beat 0: valids drop immediately. After release, ready=1, and a new read returns only new data.
